// File: rtl/acquire_control.sv
// Logic-analyser acquisition controller: trigger on edge or pattern, capture 2^ADDR_W samples, dump over UART.
// Define ACQ_HEADER_EN to prefix the dump with 0xA5 and the latched sampling rate.
module acquire_control #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [28:0]       configuration,
  input  logic              configuration_valid,
  input  logic              arm,
  input  logic [7:0]        sample_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              triggered
);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, FETCH, SEND, HOLD} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t      state;
  logic [28:0] cfg;
  logic [7:0]  div;
  logic [7:0]  prev_sample;
  logic        first_tick;
  logic        fetch_wait;
`ifdef ACQ_HEADER_EN
  logic [1:0]  hdr;
`endif

  logic [7:0] cfg_rate, cfg_thr, cfg_pat, mask;
  logic [3:0] cfg_len;
  logic       cfg_edge, tick, fire;

  assign cfg_rate = cfg[28:21];
  assign cfg_edge = cfg[20];
  assign cfg_thr  = cfg[19:12];
  assign cfg_len  = cfg[11:8];
  assign cfg_pat  = cfg[7:0];

  always_comb begin
    tick = (div == cfg_rate);
    mask = (cfg_len >= 4'd8) ? 8'hFF : ~(8'hFF << cfg_len);
    if (cfg_len == 4'd0)
      // edge mode has no valid previous sample on the first tick of a run
      fire = !first_tick && (cfg_edge ? (prev_sample <  cfg_thr && sample_in >= cfg_thr)
                                      : (prev_sample >= cfg_thr && sample_in <  cfg_thr));
    else
      fire = ((sample_in ^ cfg_pat) & mask) == 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg         <= '0;
      div         <= '0;
      prev_sample <= '0;
      first_tick  <= 1'b0;
      fetch_wait  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      triggered   <= 1'b0;
`ifdef ACQ_HEADER_EN
      hdr         <= '0;
`endif
    end else begin
      mem_we   <= 1'b0;
      tx_start <= 1'b0;
      if (state == ARMED || state == CAPTURE)
        div <= tick ? '0 : div + 8'd1;

      case (state)
        IDLE: begin
          if (arm && configuration_valid) begin
            cfg        <= configuration;
            triggered  <= 1'b0;
            div        <= '0;
            mem_addr   <= '0;
            first_tick <= 1'b1;
            busy       <= 1'b1;
            state      <= ARMED;
          end
        end
        ARMED: begin
          if (tick) begin
            prev_sample <= sample_in;
            first_tick  <= 1'b0;
            if (fire) begin
              mem_we    <= 1'b1;
              mem_addr  <= '0;
              mem_wdata <= sample_in;
              triggered <= 1'b1;
              state     <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          // mem_we/mem_addr show the write committing on this edge
          if (mem_we && mem_addr == LAST) begin
            mem_addr <= '0;
`ifdef ACQ_HEADER_EN
            tx_data  <= 8'hA5;
            hdr      <= 2'd2;
            state    <= SEND;
`else
            state    <= FETCH;
`endif
          end else if (tick) begin
            mem_we    <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= sample_in;
          end
        end
        FETCH: begin
          // first cycle presents the address, second cycle has mem_rdata valid
          if (!fetch_wait) begin
            fetch_wait <= 1'b1;
          end else begin
            fetch_wait <= 1'b0;
            tx_data    <= mem_rdata;
            state      <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
`ifdef ACQ_HEADER_EN
          if (hdr == 2'd2) begin
            tx_data <= cfg_rate;
            hdr     <= 2'd1;
            state   <= SEND;
          end else if (hdr == 2'd1) begin
            hdr   <= 2'd0;
            state <= FETCH;
          end else
`endif
          if (mem_addr == LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acquire_control.sv
// Bench for acquire_control (ADDR_W=3): reference model derives trigger point, buffer and UART stream from the sample stream.
module tb_acquire_control;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [28:0]   configuration;
  logic          configuration_valid;
  logic          arm;
  logic [7:0]    sample_in;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          busy;
  logic          triggered;

  int total = 0;
  int bad   = 0;

  logic [7:0] samp [0:4095];
  logic [7:0] mem  [0:DEPTH-1];

  acquire_control #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .configuration(configuration),
    .configuration_valid(configuration_valid), .arm(arm), .sample_in(sample_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .triggered(triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous capture buffer: read data valid one cycle after the address
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arms one acquisition at the current time and follows it until busy drops.
  task automatic run_acq(input int r, input logic edge_sel, input logic [7:0] thr,
                         input logic [3:0] len, input logic [7:0] pat,
                         input int hold, input bit poke_arm);
    int T, w, busy_cnt, L, m, s, p, fire_cycle, start_age;
    bit hit, done;
    logic [7:0] exp_buf [DEPTH];
    logic [7:0] q[$];
    logic [7:0] got[$];
    logic [7:0] last;

    T = -1;
    p = 0;
    for (int t = 0; t < 300; t++) begin
      s = int'(samp[t*(r+1)+r]);
      if (t > 0) p = int'(samp[(t-1)*(r+1)+r]);
      if (len != 4'd0) begin
        L   = (len > 4'd8) ? 8 : int'(len);
        m   = 1 << L;
        hit = (s % m) == (int'(pat) % m);
      end else begin
        hit = (t > 0) && (edge_sel ? (p <  int'(thr) && s >= int'(thr))
                                   : (p >= int'(thr) && s <  int'(thr)));
      end
      if (hit && T < 0) T = t;
    end
    chk("model_trigger_found", 32'(T >= 0), 32'd1);
    if (T < 0) return;

    for (int i = 0; i < DEPTH; i++) exp_buf[i] = samp[(T+i)*(r+1)+r];
`ifdef ACQ_HEADER_EN
    q.push_back(8'hA5);
    q.push_back(8'(r));
`endif
    for (int i = 0; i < DEPTH; i++) q.push_back(exp_buf[i]);
    fire_cycle = T*(r+1)+r;

    configuration       = {8'(r), edge_sel, thr, len, pat};
    configuration_valid = 1'b1;
    arm                 = 1'b1;
    tx_busy             = 1'b0;
    w = 0; busy_cnt = 0; done = 0; start_age = -1; last = '0;

    for (int k = 0; k < 3000 && !done; k++) begin
      @(posedge clk); #1;
      arm = 1'b0;
      if (k == 0) begin
        chk("busy_after_arm", 32'(busy), 32'd1);
        chk("triggered_cleared", 32'(triggered), 32'd0);
        configuration = 29'($urandom);
      end
      if (poke_arm && k == 2) arm = 1'b1;
      sample_in = samp[k];
      if (k == fire_cycle) chk("triggered_before_fire", 32'(triggered), 32'd0);
      if (mem_we) begin
        if (w < DEPTH) begin
          chk("wr_cycle", 32'(k), 32'((T+w)*(r+1)+r+1));
          chk("wr_addr", 32'(mem_addr), 32'(w));
          chk("wr_data", 32'(mem_wdata), 32'(exp_buf[w]));
          if (w == 0) chk("triggered_on_fire", 32'(triggered), 32'd1);
        end
        w++;
      end
      if (start_age == 1) chk("tx_data_stable", 32'(tx_data), 32'(last));
      if (tx_start) begin
        chk("tx_start_while_busy", 32'(busy_cnt), 32'd0);
        got.push_back(tx_data);
        last      = tx_data;
        busy_cnt  = hold;
        start_age = 0;
      end
      if (start_age >= 0) start_age++;
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      done = (k > 0) && (busy === 1'b0);
    end
    tx_busy = 1'b0;

    chk("run_complete", 32'(done), 32'd1);
    chk("write_count", 32'(w), 32'(DEPTH));
    chk("byte_count", 32'(got.size()), 32'(q.size()));
    for (int i = 0; i < q.size(); i++)
      if (i < got.size()) chk("tx_byte", 32'(got[i]), 32'(q[i]));
    chk("triggered_held", 32'(triggered), 32'd1);
  endtask

  task automatic rand_run();
    int r, c5, c6;
    logic e;
    logic [7:0] thr, pat;
    logic [3:0] len;
    r   = $urandom_range(0, 4);
    e   = 1'($urandom);
    thr = 8'($urandom_range(1, 255));
    len = 4'($urandom_range(0, 15));
    pat = 8'($urandom);
    for (int i = 0; i < 4096; i++) samp[i] = 8'($urandom);
    c5 = 5*(r+1)+r;
    c6 = 6*(r+1)+r;
    if (len != 4'd0) samp[c6] = pat;
    else if (e) begin samp[c5] = 8'h00; samp[c6] = 8'hFF; end
    else        begin samp[c5] = 8'hFF; samp[c6] = 8'h00; end
    run_acq(r, e, thr, len, pat, $urandom_range(0, 20), 1'($urandom));
  endtask

  initial begin
    int k;
    rst_n = 1'b0; configuration = '0; configuration_valid = 1'b0; arm = 1'b0;
    sample_in = '0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;

    // arm without valid configuration is ignored
    configuration = {8'd0, 1'b0, 8'd0, 4'd4, 8'h05};
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    @(posedge clk); #1;
    chk("arm_no_valid_busy", 32'(busy), 32'd0);
    chk("arm_no_valid_we", 32'(mem_we), 32'd0);

    // ramp, 4-bit pattern 0x5, every-cycle sampling, late arm poke
    for (int i = 0; i < 4096; i++) samp[i] = 8'(i);
    run_acq(0, 1'b0, 8'h00, 4'd4, 8'h05, 20, 1'b1);

    // rising edge across 0x80 with sample period 4
    for (int i = 0; i < 4096; i++) samp[i] = (i < 4) ? 8'h10 : 8'h90;
    run_acq(3, 1'b1, 8'h80, 4'd0, 8'h00, 20, 1'b0);

    repeat (3) rand_run();

    // reset while capture has reached address 3
    for (int i = 0; i < 4096; i++) samp[i] = 8'($urandom);
    configuration       = {8'd1, 1'b0, 8'h00, 4'd8, samp[1]};
    configuration_valid = 1'b1;
    arm                 = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      arm = 1'b0;
      sample_in = samp[k];
      if (mem_we && mem_addr == 3'd3) break;
    end
    chk("reached_addr3", 32'(mem_addr), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_triggered", 32'(triggered), 32'd0);
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    rst_n = 1'b1;

    // first edge after release accepts arm; edge mode must skip the first tick
    // even though the reset previous sample (0x00) lies below threshold
    for (int i = 0; i < 4096; i++) samp[i] = 8'h90;
    samp[2] = 8'h10;
    run_acq(0, 1'b1, 8'h40, 4'd0, 8'h00, 5, 1'b0);

    repeat (4) rand_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
